// File: rtl/bp_pkg.sv
// Shared definitions for the fetch next-PC predictor: the BTB entry layout,
// the 2-bit counter encodings and the fetch reset vector.
package bp_pkg;

  localparam int ENTRY_W   = 35;
  localparam int IDX_W     = 5;
  localparam int VALID_BIT = 34;
  localparam int CTR_HI    = 33;
  localparam int CTR_LO    = 32;
  localparam int TGT_MSB   = 31;

  localparam logic [1:0] WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;
  localparam logic [1:0] CTR_MIN    = 2'b00;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Field order matches the flat entry: [34] valid, [33:32] ctr, [31:0] target.
  typedef struct packed {
    logic        valid;
    logic [1:0]  ctr;
    logic [31:0] target;
  } btb_entry_t;

  // An entry predicts taken only when it is valid and its counter is in a taken state.
  function automatic logic entry_pred_taken(input btb_entry_t e);
    return e.valid & e.ctr[1];
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Two-bit saturating up/down counter, next-value only; the owner holds the state.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_MIN) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch PC register, same-cycle BTB prediction, EX-side resolution with
// flush/redirect, and the registered BTB update write port.
module next_pc_predictor
  import bp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic [31:0]        pc,
  output logic [IDX_W-1:0]   btb_r_address,
  input  logic [ENTRY_W-1:0] btb_re_data,
  output logic [ENTRY_W-1:0] pred_entry,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ex_taken,
  input  logic [31:0]        ex_target,
  input  logic [ENTRY_W-1:0] ex_pred_entry,
  output logic               flush,
  output logic [IDX_W-1:0]   btb_w_address,
  output logic [ENTRY_W-1:0] btb_wr_data,
  output logic               btb_we,
  output logic [15:0]        mispredict_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic             btb_we_q, btb_we_d;
  logic [IDX_W-1:0] w_addr_q, w_addr_d;
  btb_entry_t       wr_entry_q, wr_entry_d;
  logic             last_wr_valid_q, last_wr_valid_d;
  logic [15:0]      mis_cnt_q, mis_cnt_d;

  btb_entry_t       rd_entry;
  btb_entry_t       ex_entry;
  btb_entry_t       eff_entry;
  logic [IDX_W-1:0] ex_idx;
  logic             fwd_hit;
  logic             mispredict;
  logic [1:0]       ctr_next;
  logic [31:0]      redirect_pc;

  assign rd_entry      = btb_entry_t'(btb_re_data);
  assign ex_entry      = btb_entry_t'(ex_pred_entry);
  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign btb_r_address = pc_q[IDX_W+1:2];
  assign pred_entry    = btb_re_data;

  // The entry EX carries may predate a write still held on the write port,
  // so the held write wins when it targets the same index.
  always_comb begin
    fwd_hit   = last_wr_valid_q && (w_addr_q == ex_idx);
    eff_entry = fwd_hit ? wr_entry_q : ex_entry;
  end

  always_comb begin
    mispredict = 1'b0;
    if (ex_valid) begin
      mispredict = (ex_taken != entry_pred_taken(eff_entry)) ||
                   (ex_taken && (eff_entry.target != ex_target));
    end
  end

  assign flush = rst & mispredict;

  bp_sat_ctr u_sat_ctr (
    .ctr_i (eff_entry.ctr),
    .up_i  (ex_taken),
    .ctr_o (ctr_next)
  );

  always_comb begin
    redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    if (flush) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (entry_pred_taken(rd_entry)) begin
      pc_d = rd_entry.target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Write address/data stay put between writes; only the strobe pulses.
  always_comb begin
    btb_we_d   = 1'b0;
    w_addr_d   = w_addr_q;
    wr_entry_d = wr_entry_q;
    if (ex_valid) begin
      if (!eff_entry.valid) begin
        if (ex_taken) begin
          btb_we_d          = 1'b1;
          w_addr_d          = ex_idx;
          wr_entry_d.valid  = 1'b1;
          wr_entry_d.ctr    = WEAK_TAKEN;
          wr_entry_d.target = ex_target;
        end
      end else begin
        btb_we_d          = 1'b1;
        w_addr_d          = ex_idx;
        wr_entry_d.valid  = 1'b1;
        wr_entry_d.ctr    = ctr_next;
        wr_entry_d.target = ex_taken ? ex_target : eff_entry.target;
      end
    end
    last_wr_valid_d = last_wr_valid_q | btb_we_d;
  end

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (flush && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q            <= RESET_PC;
      btb_we_q        <= 1'b0;
      w_addr_q        <= '0;
      wr_entry_q      <= '0;
      last_wr_valid_q <= 1'b0;
      mis_cnt_q       <= '0;
    end else begin
      pc_q            <= pc_d;
      btb_we_q        <= btb_we_d;
      w_addr_q        <= w_addr_d;
      wr_entry_q      <= wr_entry_d;
      last_wr_valid_q <= last_wr_valid_d;
      mis_cnt_q       <= mis_cnt_d;
    end
  end

  assign pc             = pc_q;
  assign btb_we         = btb_we_q;
  assign btb_w_address  = w_addr_q;
  assign btb_wr_data    = wr_entry_q;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor: a reference model checked every cycle
// plus hand-computed literal expectations along the directed sequence.
module tb_next_pc_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic [4:0]  btb_r_address;
  logic [34:0] btb_re_data;
  logic [34:0] pred_entry;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [34:0] ex_pred_entry;
  logic        flush;
  logic [4:0]  btb_w_address;
  logic [34:0] btb_wr_data;
  logic        btb_we;
  logic [15:0] mispredict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  next_pc_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc             (pc),
    .btb_r_address  (btb_r_address),
    .btb_re_data    (btb_re_data),
    .pred_entry     (pred_entry),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_entry  (ex_pred_entry),
    .flush          (flush),
    .btb_w_address  (btb_w_address),
    .btb_wr_data    (btb_wr_data),
    .btb_we         (btb_we),
    .mispredict_cnt (mispredict_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: remembers the most recent write and the architectural state
  logic        m_ready = 1'b0;
  logic [31:0] m_pc;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [34:0] m_wd;
  logic        m_have_wr;
  int          m_cnt;

  function automatic logic [34:0] m_eff();
    if (m_have_wr && m_wa == ex_pc[6:2]) return m_wd;
    return ex_pred_entry;
  endfunction

  function automatic logic m_mispredict();
    logic [34:0] e;
    logic        predicted;
    e = m_eff();
    predicted = e[34] && e[33];
    if (!ex_valid) return 1'b0;
    return (ex_taken != predicted) || (ex_taken && e[31:0] != ex_target);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_ready = 1'b1; m_pc = 32'h0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      m_have_wr = 1'b0; m_cnt = 0;
    end else if (m_ready) begin
      logic [34:0] e;
      logic        mis;
      int          c;
      e   = m_eff();
      mis = m_mispredict();
      if (mis) m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      else if (stall) m_pc = m_pc;
      else if (btb_re_data[34] && btb_re_data[33]) m_pc = btb_re_data[31:0];
      else m_pc = m_pc + 32'd4;
      if (mis && m_cnt < 65535) m_cnt++;
      m_we = 1'b0;
      if (ex_valid && !e[34] && ex_taken) begin
        m_we = 1'b1; m_wa = ex_pc[6:2]; m_wd = {1'b1, 2'b10, ex_target};
      end else if (ex_valid && e[34]) begin
        c = int'(e[33:32]);
        c = ex_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        m_we = 1'b1; m_wa = ex_pc[6:2];
        m_wd = {1'b1, 2'(c), ex_taken ? ex_target : e[31:0]};
      end
      if (m_we) m_have_wr = 1'b1;
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (m_ready) begin
      check("pc", pc, m_pc);
      check("btb_r_address", btb_r_address, m_pc[6:2]);
      check("pred_entry", pred_entry, btb_re_data);
      check("flush", flush, rst && m_mispredict());
      check("btb_we", btb_we, m_we);
      check("btb_w_address", btb_w_address, m_wa);
      check("btb_wr_data", btb_wr_data, m_wd);
      check("mispredict_cnt", mispredict_cnt, 16'(m_cnt));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic v, input logic [31:0] p, input logic t,
                          input logic [31:0] tgt, input logic [34:0] pe);
    ex_valid = v; ex_pc = p; ex_taken = t; ex_target = tgt; ex_pred_entry = pe;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; btb_re_data = '0;
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 35'h0);
    step(); step();
    check("reset_pc", pc, 32'h0);
    check("reset_we", btb_we, 1'b0);
    check("reset_cnt", mispredict_cnt, 16'h0);
    check("reset_flush", flush, 1'b0);
    rst = 1'b1;
    #1;
    check("release_pc0", pc, 32'h0);
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8);
    step(); step();
    check("seq_pc10", pc, 32'h10);

    // BTB hit, strongly taken
    btb_re_data = {1'b1, 2'b11, 32'h40};
    #1;
    check("hit_pred_entry", pred_entry, {1'b1, 2'b11, 32'h40});
    check("hit_r_addr", btb_r_address, 5'd4);
    step(); check("hit_pc", pc, 32'h40);
    btb_re_data = '0;

    // taken branch with an empty entry: flush, redirect, allocate weak-taken
    ex_drive(1'b1, 32'h20, 1'b1, 32'h80, 35'h0);
    #1; check("alloc_flush", flush, 1'b1);
    step();
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 35'h0);
    check("alloc_pc", pc, 32'h80);
    check("alloc_we", btb_we, 1'b1);
    check("alloc_waddr", btb_w_address, 5'd8);
    check("alloc_wdata", btb_wr_data, {1'b1, 2'b10, 32'h80});
    check("alloc_cnt", mispredict_cnt, 16'd1);
    step(); check("alloc_we_pulse", btb_we, 1'b0);

    // saturate high, then saturate low without a flush
    ex_drive(1'b1, 32'h100, 1'b1, 32'h200, {1'b1, 2'b11, 32'h200});
    #1; check("sat_hi_flush", flush, 1'b0);
    step(); check("sat_hi_wdata", btb_wr_data, {1'b1, 2'b11, 32'h200});
    ex_drive(1'b1, 32'h104, 1'b0, 32'h0, {1'b1, 2'b00, 32'h300});
    #1; check("sat_lo_flush", flush, 1'b0);
    step(); check("sat_lo_wdata", btb_wr_data, {1'b1, 2'b00, 32'h300});
    check("sat_lo_waddr", btb_w_address, 5'd1);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 35'h0);
    step();

    // back-to-back not-taken at 0x20 with a stale entry
    ex_drive(1'b1, 32'h20, 1'b0, 32'h0, {1'b1, 2'b10, 32'h80});
    #1; check("b2b_first_flush", flush, 1'b1);
    step();
    check("b2b_first_wdata", btb_wr_data, {1'b1, 2'b01, 32'h80});
    check("b2b_first_pc", pc, 32'h24);
    check("b2b_second_flush", flush, 1'b0);
    step();
    check("b2b_second_wdata", btb_wr_data, {1'b1, 2'b00, 32'h80});
    check("b2b_second_we", btb_we, 1'b1);
    check("b2b_cnt", mispredict_cnt, 16'd2);

    // flush beats stall, redirect wraps past the top of memory
    stall = 1'b1;
    ex_drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, {1'b1, 2'b11, 32'h0});
    #1; check("wrap_flush", flush, 1'b1);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_cnt", mispredict_cnt, 16'd3);
    check("wrap_waddr", btb_w_address, 5'd31);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 35'h0);
    btb_re_data = {1'b1, 2'b11, 32'h500};
    step(); check("stall_hold_pc", pc, 32'h0);
    stall = 1'b0;
    step(); check("unstall_pred_pc", pc, 32'h500);
    btb_re_data = '0;
    step(); check("post_pred_pc", pc, 32'h504);

    // reset on the same edge as a resolving branch drops its write
    ex_drive(1'b1, 32'h40, 1'b1, 32'h99C, 35'h0);
    rst = 1'b0;
    #1; check("rst_flush_low", flush, 1'b0);
    step();
    check("rst_drop_we", btb_we, 1'b0);
    check("rst_cnt", mispredict_cnt, 16'h0);
    check("rst_pc", pc, 32'h0);
    rst = 1'b1;
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 35'h0);
    step();
    check("after_rst_we", btb_we, 1'b0);
    check("after_rst_pc", pc, 32'h4);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
